double_dabble_seq: RTL
======================

# double_dabble_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock. It sits directly downstream of the edge-triggered flip-flop storage stage and is built on that register behaviour. It takes a latched binary word on a start pulse and returns packed BCD digits with a one-cycle done pulse for the display/output stage.

## Interface

Parameters:
- WIDTH, 8, binary input width in bits (≥1).
- DIGITS, 3, number of BCD output digits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous, active-high. Clears all state immediately.
- start  input  1  request a conversion; honoured only when busy=0.
- bin  input  WIDTH  binary operand; sampled on the clk edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd and overflow are valid and updated.
- bcd  output  4*DIGITS  packed result; digit 0 in bits [3:0].
- overflow  output  1  result ≥ 10^DIGITS; the bcd digits hold the value mod 10^DIGITS.

## Operation

- States: IDLE, CONV, DONE.
- IDLE: busy=0, done=0. When start=1 at an edge: load bin into the shift register, clear the BCD scratch and overflow scratch, set bit counter = WIDTH, and go to CONV.
- CONV: each edge does one iteration on every scratch digit.
  - Add 3 to every digit whose value is ≥5.
  - Shift {scratch, binreg} left by 1.
  - If the bit shifted out of the top digit is 1, set the overflow scratch.
  - Decrement the counter.
  - On the iteration where the counter goes 1→0, copy the result into bcd and overflow, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. A start in DONE is accepted exactly as in IDLE (loads and goes to CONV), which allows back-to-back conversions.
- start while busy=1 is ignored, with no queueing. bin is don't-care except on the accepting edge.
- bcd and overflow hold their last result until the next done. They never show intermediate scratch values.
- Digit adjust uses a 4-bit compare (≥5) and add (+3). A digit is ≤9 before each adjust, so no carry out of the 4-bit add.
- Counter width: clog2(WIDTH+1) bits.

## Timing

- Reset values: state=IDLE, busy=0, done=0, bcd=0, overflow=0, counter=0, scratch=0.
- rst asserted mid-conversion aborts immediately. No done is produced. Operation resumes in IDLE after release.
- Start accepted at edge E0. busy goes high after E0.
- Iterations happen at edges E1..E_WIDTH. bcd, overflow and done become valid after E_WIDTH.
- done is high for the cycle between E_WIDTH and E_WIDTH+1, with busy=0 in that cycle.
- Latency from the accepting edge to the done-high cycle: WIDTH edges. Throughput: one conversion per WIDTH+1 cycles when back-to-back.
- Outputs are registered, with no combinational path from input to output.

## Structure

- Shared package dd_pkg:
  - State encoding constants IDLE=2'd0, CONV=2'd1, DONE=2'd2.
  - Constant BCD_ADJ_THRESH=4'd5, BCD_ADJ_ADD=4'd3.
  - clog2 function for the counter width.
- One sub-module: dd_add3, a combinational 4-bit digit cell (out = in≥5 ? in+3 : in), instantiated DIGITS times with a generate loop.
- All registers live in double_dabble_seq. Each register has an asynchronous clear on rst.

## Test plan

- WIDTH=8, DIGITS=3: start with bin=8'd255 → done exactly 8 edges after acceptance, bcd=12'h255, overflow=0, busy high for the 8 intervening cycles.
- bin=8'd0, then bin=8'd99 → bcd=12'h000, then bcd=12'h099. Check that bcd holds each value until the next done.
- Start pulsed again at E3 of a conversion of 8'd128 with bin=8'd7 → ignored. Result bcd=12'h128 with a single done.
- Start asserted during the done cycle of 8'd42 with bin=8'd250 → second conversion accepted immediately. done pulses for 12'h042, then 12'h250 nine cycles later.
- rst asserted asynchronously (off-edge) at E4 of a conversion → busy, done, bcd and overflow are 0 at once. No done follows. A subsequent conversion of 8'd10 yields 12'h010.
- WIDTH=8, DIGITS=2: bin=8'd200 → overflow=1, bcd=8'h00. bin=8'd99 → overflow=0, bcd=8'h99.

Source files
------------

// File: rtl/dd_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
package dd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dd_add3.sv
// Combinational BCD digit cell: adds 3 to a digit of 5 or more before it is doubled.
module dd_add3
    import dd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Input is at most 9, so the 4-bit sum never carries out.
    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_ADD : digit_i;

endmodule

// File: rtl/double_dabble_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 iteration per clock.
module double_dabble_seq
    import dd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = clog2(WIDTH + 1);

    state_e           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [SW-1:0]    scratch_q;
    logic             ovf_scratch_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [SW-1:0]    bcd_q;
    logic             overflow_q;

    logic [SW-1:0]       adj;
    logic [SW+WIDTH:0]   shift_d;
    logic [SW-1:0]       scratch_d;
    logic [WIDTH-1:0]    bin_d;
    logic                ovf_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        dd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    // The extra top bit of the shift is the carry out of the most significant digit.
    assign shift_d   = {adj, bin_q, 1'b0};
    assign scratch_d = shift_d[SW+WIDTH-1:WIDTH];
    assign bin_d     = shift_d[WIDTH-1:0];
    assign ovf_d     = ovf_scratch_q | shift_d[SW+WIDTH];

    // NOTE: every register, scratch included, clears on rst so an aborted conversion leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bin_q         <= '0;
            scratch_q     <= '0;
            ovf_scratch_q <= 1'b0;
            count_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bcd_q         <= '0;
            overflow_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bin_q         <= bin;
                        scratch_q     <= '0;
                        ovf_scratch_q <= 1'b0;
                        count_q       <= CW'(WIDTH);
                        busy_q        <= 1'b1;
                        state_q       <= CONV;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CONV: begin
                    scratch_q     <= scratch_d;
                    bin_q         <= bin_d;
                    ovf_scratch_q <= ovf_d;
                    count_q       <= count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        bcd_q      <= scratch_d;
                        overflow_q <= ovf_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
